updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised successor to the fixed 4-bit up/down counter pair.
- Provides one counter with run-time direction, count enable, synchronous load, modulo limit, and wrap/saturate mode.
- Reports boundary status, a one-cycle terminal-count pulse and a sticky wrap tally.
- Used as the counting primitive in the top level and in future timer/sequencer blocks.

Parameters:
- WIDTH, 4: counter width in bits; 2 to 32.
- MAX_VAL, 2**WIDTH-1: upper count limit, so the count range is 0..MAX_VAL. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- WRAP_W, 8: width of the wrap tally counter.
- RST_VAL, 0: count value on reset. Must be <= MAX_VAL.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- clr_wrap  input  1  synchronous clear of wrap_cnt.
- count  output  WIDTH  current count.
- at_max  output  1  combinational: count == MAX_VAL.
- at_min  output  1  combinational: count == 0.
- tc  output  1  registered terminal-count pulse.
- wrap_cnt  output  WRAP_W  sticky-saturating tally of wraps.

Behaviour:
- Reset (rst=0, asynchronous): count=RST_VAL, tc=0, wrap_cnt=0. at_max and at_min follow count.
- Release of rst is sampled synchronously; the first update happens on the first rising edge with rst=1.
- Priority each edge: load > en > hold.
- Load:
  - count <= min(load_val, MAX_VAL). Values above MAX_VAL clamp to MAX_VAL.
  - tc <= 0.
  - The en step is ignored in the same cycle.
- Enabled step, up (up_dn=1):
  - count < MAX_VAL: count+1.
  - count == MAX_VAL, wrap mode: count <= 0, tc <= 1, wrap_cnt increments.
  - count == MAX_VAL, saturate mode: count holds, tc <= 1, wrap_cnt unchanged.
- Enabled step, down (up_dn=0):
  - count > 0: count-1.
  - count == 0, wrap mode: count <= MAX_VAL, tc <= 1, wrap_cnt increments.
  - count == 0, saturate mode: count holds, tc <= 1.
- tc latency and width:
  - tc is high for exactly the one cycle after the boundary edge; otherwise 0.
  - In saturate mode with en held at the boundary, tc stays high every cycle.
- Arithmetic: boundary compares use MAX_VAL, never 2**WIDTH. There is no intermediate overflow; the next count is always selected, never computed modulo 2**WIDTH.
- wrap_cnt:
  - Saturates at all-ones and does not roll over.
  - clr_wrap zeroes it.
  - clr_wrap together with a wrap event in the same cycle: the clear wins, result 0.
- Direction or mode changes take effect on the same edge they are sampled; no pipeline.
- Reset asserted mid-count: immediate return to reset values, independent of clk.
- Load while en is low: load still occurs.

Test Plan:
- Reset check (WIDTH=4, MAX_VAL=9, RST_VAL=0): hold rst=0 over 3 edges, then release with en=0 -> count=0, at_min=1, tc=0, wrap_cnt=0. Assert rst mid-cycle at count=5 -> count=0 before the next edge.
- Up wrap (wrap mode): en=1, up_dn=1 from 0 for 12 edges -> count 1..9, 0, 1, 2. tc=1 only in the cycle count first reads 0. wrap_cnt=1. at_max=1 while count=9.
- Down wrap and saturate:
  - Down from 0, wrap mode -> count goes 0 -> 9, tc pulses, wrap_cnt increments.
  - Then sat_mode=1, load 1, count down for 3 edges -> count 0, 0, 0. tc=1 on the 2nd and 3rd cycles; wrap_cnt unchanged.
- Load priority and clamp:
  - load=1, en=1, load_val=4 -> count=4 with no step.
  - load_val=15 -> count=9 (clamped).
- Wrap tally (WRAP_W=2):
  - 5 up-wraps -> wrap_cnt reads 1, 2, 3, 3, 3.
  - clr_wrap coincident with a wrap edge -> wrap_cnt=0.
- Direction flip: count to 3 going up, set up_dn=0 on the next edge -> count 3 -> 2 -> 1, with no tc and no skipped or duplicated value.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulo limit, wrap/saturate boundary mode,
// terminal-count pulse and a saturating tally of wrap events.
module updown_counter_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1,
    parameter int unsigned WRAP_W  = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_dn,
    input  logic              sat_mode,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_wrap,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              tc,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WIDTH-1:0]  MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]  RST_C  = WIDTH'(RST_VAL);
    localparam logic [WRAP_W-1:0] WRAP_F = {WRAP_W{1'b1}};

    logic [WIDTH-1:0]  count_q, count_nxt;
    logic [WRAP_W-1:0] wrap_q, wrap_nxt;
    logic              tc_q, tc_nxt;
    logic              wrap_ev;

    // Next count is always selected from bounded candidates, never taken modulo 2**WIDTH.
    always_comb begin
        count_nxt = count_q;
        tc_nxt    = 1'b0;
        wrap_ev   = 1'b0;
        if (load) begin
            count_nxt = (load_val > MAX_C) ? MAX_C : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (count_q == MAX_C) begin
                    tc_nxt = 1'b1;
                    if (!sat_mode) begin
                        count_nxt = '0;
                        wrap_ev   = 1'b1;
                    end
                end else begin
                    count_nxt = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_nxt = 1'b1;
                    if (!sat_mode) begin
                        count_nxt = MAX_C;
                        wrap_ev   = 1'b1;
                    end
                end else begin
                    count_nxt = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Clear beats a simultaneous wrap; the tally sticks at all-ones.
    always_comb begin
        wrap_nxt = wrap_q;
        if (clr_wrap) begin
            wrap_nxt = '0;
        end else if (wrap_ev && (wrap_q != WRAP_F)) begin
            wrap_nxt = wrap_q + WRAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_C;
            tc_q    <= 1'b0;
            wrap_q  <= '0;
        end else begin
            count_q <= count_nxt;
            tc_q    <= tc_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign wrap_cnt = wrap_q;
    assign at_max   = (count_q == MAX_C);
    assign at_min   = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed vector table on a 0..9 instance plus a
// reference model checking a second, differently parametrised instance and random traffic.
module tb_updown_counter_param;

    localparam int unsigned A_W = 4, A_MAX = 9,  A_WW = 2, A_RST = 0;
    localparam int unsigned B_W = 5, B_MAX = 20, B_WW = 3, B_RST = 7;
    localparam int A_WMAX = 2**A_WW - 1;
    localparam int B_WMAX = 2**B_WW - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, up_dn, sat_mode, load, clr_wrap;
    logic [A_W-1:0]  lv_a, cnt_a;
    logic [B_W-1:0]  lv_b, cnt_b;
    logic            amax_a, amin_a, tc_a, amax_b, amin_b, tc_b;
    logic [A_WW-1:0] wc_a;
    logic [B_WW-1:0] wc_b;

    updown_counter_param #(.WIDTH(A_W), .MAX_VAL(A_MAX), .WRAP_W(A_WW), .RST_VAL(A_RST)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
        .load_val(lv_a), .clr_wrap(clr_wrap), .count(cnt_a), .at_max(amax_a),
        .at_min(amin_a), .tc(tc_a), .wrap_cnt(wc_a)
    );

    updown_counter_param #(.WIDTH(B_W), .MAX_VAL(B_MAX), .WRAP_W(B_WW), .RST_VAL(B_RST)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .load(load),
        .load_val(lv_b), .clr_wrap(clr_wrap), .count(cnt_b), .at_max(amax_b),
        .at_min(amin_b), .tc(tc_b), .wrap_cnt(wc_b)
    );

    typedef struct {
        bit ld, e, up, sat, clr;
        int lv;
        int ec;
        bit etc;
        int ew;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state for both instances
    int ma_c, ma_w, mb_c, mb_w;
    bit ma_tc, mb_tc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit ld, e, up, sat, clr, input int lv, ec, input bit etc, input int ew);
        vec_t v;
        v.ld = ld; v.e = e; v.up = up; v.sat = sat; v.clr = clr;
        v.lv = lv; v.ec = ec; v.etc = etc; v.ew = ew;
        return v;
    endfunction

    function automatic void model_step(input int mx, input int wmax, input int c, input int w,
                                       input bit ld, e, up, sat, clr, input int lv,
                                       output int nc, output bit ntc, output int nw);
        int t;
        bit wrapped;
        wrapped = 1'b0;
        nc  = c;
        ntc = 1'b0;
        if (ld) begin
            nc = (lv > mx) ? mx : lv;
        end else if (e) begin
            t = up ? c + 1 : c - 1;
            if (t > mx || t < 0) begin
                ntc = 1'b1;
                if (!sat) begin
                    nc = up ? 0 : mx;
                    wrapped = 1'b1;
                end
            end else begin
                nc = t;
            end
        end
        if (clr)          nw = 0;
        else if (wrapped) nw = (w + 1 > wmax) ? wmax : w + 1;
        else              nw = w;
    endfunction

    task automatic model_reset();
        ma_c = A_RST; ma_w = 0; ma_tc = 1'b0;
        mb_c = B_RST; mb_w = 0; mb_tc = 1'b0;
    endtask

    // One clock edge; models advance on the same sampled inputs, outputs are read 1ns later
    task automatic tick();
        int nc, nw;
        bit ntc;
        @(posedge clk);
        if (rst) begin
            model_step(A_MAX, A_WMAX, ma_c, ma_w, load, en, up_dn, sat_mode, clr_wrap, int'(lv_a), nc, ntc, nw);
            ma_c = nc; ma_tc = ntc; ma_w = nw;
            model_step(B_MAX, B_WMAX, mb_c, mb_w, load, en, up_dn, sat_mode, clr_wrap, int'(lv_b), nc, ntc, nw);
            mb_c = nc; mb_tc = ntc; mb_w = nw;
        end
        #1;
    endtask

    task automatic check_a_model(input string tag);
        check({tag, "_a_count"}, 32'(cnt_a), 32'(ma_c));
        check({tag, "_a_tc"},    32'(tc_a),  32'(ma_tc));
        check({tag, "_a_wrap"},  32'(wc_a),  32'(ma_w));
        check({tag, "_a_atmax"}, 32'(amax_a), 32'(ma_c == A_MAX));
        check({tag, "_a_atmin"}, 32'(amin_a), 32'(ma_c == 0));
    endtask

    task automatic check_b_model(input string tag);
        check({tag, "_b_count"}, 32'(cnt_b), 32'(mb_c));
        check({tag, "_b_tc"},    32'(tc_b),  32'(mb_tc));
        check({tag, "_b_wrap"},  32'(wc_b),  32'(mb_w));
        check({tag, "_b_atmax"}, 32'(amax_b), 32'(mb_c == B_MAX));
        check({tag, "_b_atmin"}, 32'(amin_b), 32'(mb_c == 0));
    endtask

    task automatic set_in(input bit ld, e, up, sat, clr, input int lv);
        load = ld; en = e; up_dn = up; sat_mode = sat; clr_wrap = clr;
        lv_a = A_W'(lv);
        lv_b = B_W'($urandom);
    endtask

    // Reset asserted between edges must take effect without a clock edge
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_a_model({tag, "_async"});
        check_b_model({tag, "_async"});
        set_in(0, 1, 1, 0, 0, 0);
        tick();
        check_a_model({tag, "_held"});
        rst = 1'b1;
    endtask

    initial begin
        // Directed table on instance A (0..9, 2-bit tally)
        for (int i = 1; i <= 12; i++) tbl.push_back(mk(0, 1, 1, 0, 0, 0, i % 10, i == 10, (i >= 10) ? 1 : 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 4,  4, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 15, 9, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  9, 1, 2));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1,  1, 0, 2));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,  0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,  0, 1, 2));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,  0, 1, 2));
        tbl.push_back(mk(1, 0, 1, 1, 0, 9,  9, 0, 2));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,  9, 1, 2));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,  9, 0, 2));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,  9, 1, 2));
        tbl.push_back(mk(1, 0, 1, 0, 1, 9,  9, 0, 0));
        for (int k = 1; k <= 5; k++) begin
            tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, (k > 3) ? 3 : k));
            tbl.push_back(mk(1, 0, 1, 0, 0, 9, 9, 0, (k > 3) ? 3 : k));
        end
        tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0));

        // Reset held over three edges with en high: no counting
        rst = 1'b0;
        set_in(0, 1, 1, 0, 0, 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_a_count", 32'(cnt_a), 32'(A_RST));
            check("rst_hold_b_count", 32'(cnt_b), 32'(B_RST));
        end
        rst = 1'b1;
        set_in(0, 0, 1, 0, 0, 0);
        tick();
        check("rst_rel_count", 32'(cnt_a), 32'd0);
        check("rst_rel_atmin", 32'(amin_a), 32'd1);
        check("rst_rel_tc",    32'(tc_a), 32'd0);
        check("rst_rel_wrap",  32'(wc_a), 32'd0);
        check_b_model("rst_rel");

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].ld, tbl[i].e, tbl[i].up, tbl[i].sat, tbl[i].clr, tbl[i].lv);
            tick();
            check($sformatf("vec%0d_count", i), 32'(cnt_a), 32'(tbl[i].ec));
            check($sformatf("vec%0d_tc", i),    32'(tc_a),  32'(tbl[i].etc));
            check($sformatf("vec%0d_wrap", i),  32'(wc_a),  32'(tbl[i].ew));
            check($sformatf("vec%0d_atmax", i), 32'(amax_a), 32'(tbl[i].ec == 9));
            check($sformatf("vec%0d_atmin", i), 32'(amin_a), 32'(tbl[i].ec == 0));
            check_b_model($sformatf("vec%0d", i));
        end

        // Reset while tc is high and the tally is non-zero
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0);
        tick();
        check("pre_rst_tc",   32'(tc_a), 32'd1);
        check("pre_rst_wrap", 32'(wc_a), 32'd1);
        mid_cycle_reset("rst_tc");

        // Reset mid-cycle at count 5
        set_in(1, 0, 1, 0, 0, 5);
        tick();
        check("pre_rst_count5", 32'(cnt_a), 32'd5);
        mid_cycle_reset("rst_c5");

        // Random traffic against the model on both instances
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(7, 0) == 0, $urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
                   $urandom_range(3, 0) == 0, $urandom_range(15, 0) == 0, int'($urandom_range(15, 0)));
            lv_b = B_W'($urandom);
            tick();
            check_a_model("rnd");
            check_b_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
